// File: rtl/daq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : daq_pkg
//  Description : Shared constants and encodings for the DAQ packetizer.
//  Revision    : 1.0 - initial release
// ============================================================================
package daq_pkg;

    localparam logic [7:0] C_HDR = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        SEL_HDR = 3'd0,
        SEL_SEQ = 3'd1,
        SEL_LEN = 3'd2,
        SEL_MSB = 3'd3,
        SEL_LSB = 3'd4,
        SEL_CHK = 3'd5
    } bytesel_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock show-ahead FIFO with occupancy count; the caller
//                owns all full/empty policy.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk) begin
        if (wr_en) r_mem[r_wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/daq_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : daq_packetizer
//  Description : Buffers ADC samples and emits framed, checksummed packets one
//                byte at a time through a start/busy UART handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module daq_packetizer
    import daq_pkg::*;
#(
    parameter int SAMPLE_W    = 12,
    parameter int FIFO_DEPTH  = 16,
    parameter int PKT_SAMPLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                flush,
    output logic                uart_start,
    output logic [7:0]          uart_data,
    input  logic                uart_busy,
    output logic                overflow,
    output logic [7:0]          drop_count,
    output logic                pkt_active
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] C_PKT  = CW'(PKT_SAMPLES);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    state_t              r_state, w_next;
    bytesel_t            r_sel;
    logic [7:0]          r_seq, r_len, r_chk, r_uart_data, r_sample_lo, r_drop_count;
    logic [CW-1:0]       r_remaining;
    logic                r_flush_pend, r_overflow;

    logic [SAMPLE_W-1:0] w_rd_data;
    logic [CW-1:0]       w_count, w_len;
    logic [15:0]         w_ext;
    logic [7:0]          w_byte;
    logic                w_wr, w_pop, w_start, w_pkt_start, w_advance, w_pkt_done;

    // Fullness uses the registered count, so a same-cycle pop never frees a slot.
    assign w_wr  = sample_valid && (w_count != C_FULL);
    assign w_pop = (r_state == ST_LOAD) && (r_sel == SEL_MSB);
    assign w_len = (w_count >= C_PKT) ? C_PKT : w_count;
    assign w_ext = 16'(w_rd_data);

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr),
        .wr_data (sample_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .count   (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_pkt_start = 1'b0;
        w_advance   = 1'b0;
        w_pkt_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((w_count >= C_PKT) || (r_flush_pend && (w_count != '0))) begin
                    w_next      = ST_LOAD;
                    w_pkt_start = 1'b1;
                end
            end
            ST_LOAD: w_next = ST_SEND;
            ST_SEND: begin
                if (!uart_busy) begin
                    w_start = 1'b1;
                    w_next  = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (uart_busy) w_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) begin
                    if (r_sel == SEL_CHK) begin
                        w_next     = ST_IDLE;
                        w_pkt_done = 1'b1;
                    end else begin
                        w_next    = ST_LOAD;
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_sel)
            SEL_HDR: w_byte = C_HDR;
            SEL_SEQ: w_byte = r_seq;
            SEL_LEN: w_byte = r_len;
            SEL_MSB: w_byte = w_ext[15:8];
            SEL_LSB: w_byte = r_sample_lo;
            SEL_CHK: w_byte = r_chk;
            default: w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel        <= SEL_HDR;
            r_seq        <= 8'h00;
            r_len        <= 8'h00;
            r_chk        <= 8'h00;
            r_uart_data  <= 8'h00;
            r_sample_lo  <= 8'h00;
            r_remaining  <= '0;
            r_flush_pend <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'h00;
        end else begin
            // A flush with nothing buffered is dropped once the FSM is idle.
            if (flush)
                r_flush_pend <= 1'b1;
            else if (w_pkt_start || ((r_state == ST_IDLE) && (w_count == '0)))
                r_flush_pend <= 1'b0;

            if (w_pkt_start) begin
                r_len       <= 8'(w_len);
                r_remaining <= w_len;
                r_sel       <= SEL_HDR;
            end

            if (r_state == ST_LOAD) begin
                r_uart_data <= w_byte;
                if (r_sel == SEL_HDR)
                    r_chk <= 8'h00;
                else if (r_sel != SEL_CHK)
                    r_chk <= r_chk ^ w_byte;
                if (w_pop) begin
                    r_sample_lo <= w_ext[7:0];
                    r_remaining <= r_remaining - 1'b1;
                end
            end

            if (w_advance) begin
                case (r_sel)
                    SEL_HDR: r_sel <= SEL_SEQ;
                    SEL_SEQ: r_sel <= SEL_LEN;
                    SEL_LEN: r_sel <= SEL_MSB;
                    SEL_MSB: r_sel <= SEL_LSB;
                    SEL_LSB: r_sel <= (r_remaining != '0) ? SEL_MSB : SEL_CHK;
                    default: r_sel <= SEL_CHK;
                endcase
            end

            if (w_pkt_done) r_seq <= r_seq + 8'h01;

            if (sample_valid && !w_wr) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'h01;
            end
        end
    end

    assign uart_start = w_start;
    assign uart_data  = r_uart_data;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign pkt_active = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_daq_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_daq_packetizer
//  Description : Directed scoreboard bench for daq_packetizer with a simple
//                UART busy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_daq_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample_data = 12'h000;
    logic        flush = 1'b0;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic        uart_busy;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        pkt_active;

    logic        r_busy = 1'b0;
    int          busy_cnt = 0;
    logic        hold = 1'b0;

    logic [7:0]  sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_starts = 0;

    daq_packetizer #(
        .SAMPLE_W    (12),
        .FIFO_DEPTH  (16),
        .PKT_SAMPLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .flush        (flush),
        .uart_start   (uart_start),
        .uart_data    (uart_data),
        .uart_busy    (uart_busy),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .pkt_active   (pkt_active)
    );

    always #5 clk = ~clk;

    // UART: busy the cycle after start, for three cycles; hold forces a stall.
    assign uart_busy = r_busy | hold;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy   <= 1'b0;
            busy_cnt <= 0;
        end else if (uart_start) begin
            r_busy   <= 1'b1;
            busy_cnt <= 2;
        end else if (r_busy) begin
            if (busy_cnt == 0) r_busy <= 1'b0;
            else               busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_pkt(input logic [7:0] seq, input logic [11:0] s[$]);
        logic [7:0] chk;
        logic [7:0] len;
        len = 8'(s.size());
        chk = seq ^ len;
        sb.push_back(8'hA5);
        sb.push_back(seq);
        sb.push_back(len);
        foreach (s[i]) begin
            sb.push_back({4'h0, s[i][11:8]});
            sb.push_back(s[i][7:0]);
            chk = chk ^ {4'h0, s[i][11:8]} ^ s[i][7:0];
        end
        sb.push_back(chk);
    endfunction

    always @(negedge clk) begin
        if (rst && uart_start) begin
            logic [8:0] exp_b;
            n_starts++;
            check("start_with_busy_low", {31'b0, uart_busy}, 32'd0);
            if (sb.size() != 0) exp_b = {1'b0, sb.pop_front()};
            else                exp_b = 9'h1FF;
            check("uart_byte", {23'b0, 1'b0, uart_data}, {23'b0, exp_b});
        end
    end

    task automatic drive(input logic [11:0] s[$]);
        foreach (s[i]) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_data  = s[i];
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((sb.size() != 0 || pkt_active) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'b0, (k < 5000)}, 32'd1);
    endtask

    initial begin
        logic [11:0] q[$];
        logic [11:0] q16[$];
        logic [7:0]  exp34[12];
        logic [7:0]  seq;
        logic [7:0]  d0;
        logic        stable;
        int          base;
        int          k;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_uart_start", {31'b0, uart_start}, 32'd0);
        check("rst_uart_data",  {24'b0, uart_data},  32'd0);
        check("rst_pkt_active", {31'b0, pkt_active}, 32'd0);
        check("rst_overflow",   {31'b0, overflow},   32'd0);
        check("rst_drop_count", {24'b0, drop_count}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reference packet with literal expected bytes
        exp34 = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h23, 8'h04, 8'h56,
                  8'h07, 8'h89, 8'h0A, 8'hBC, 8'h4C};
        foreach (exp34[i]) sb.push_back(exp34[i]);
        q = {12'h123, 12'h456, 12'h789, 12'hABC};
        drive(q);
        wait_idle("pkt_ref_done");
        seq = 8'h01;

        // Partial packet via flush
        q = {12'h0F1, 12'hE22};
        push_pkt(seq, q);
        drive(q);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_idle("pkt_flush_done");
        seq = seq + 8'h01;

        // Flush with empty FIFO sends nothing
        base = n_starts;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (40) @(negedge clk);
        check("flush_empty_starts", n_starts, base);
        check("flush_empty_active", {31'b0, pkt_active}, 32'd0);

        // Overflow while UART is stalled
        hold = 1'b1;
        q.delete();
        for (int i = 0; i < 17; i++) q.push_back(12'(12'h100 + i * 37));
        for (int p = 0; p < 4; p++) begin
            q16.delete();
            for (int j = 0; j < 4; j++) q16.push_back(q[p*4 + j]);
            push_pkt(seq, q16);
            seq = seq + 8'h01;
        end
        drive(q);
        @(negedge clk);
        check("ovf_flag",   {31'b0, overflow},   32'd1);
        check("ovf_drops",  {24'b0, drop_count}, 32'd1);
        check("ovf_active", {31'b0, pkt_active}, 32'd1);

        d0 = uart_data;
        stable = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (uart_data !== d0 || uart_start) stable = 1'b0;
        end
        check("hold_stable", {31'b0, stable}, 32'd1);
        check("hold_data",   {24'b0, d0},     32'hA5);
        check("hold_starts", n_starts, base);

        q.delete();
        for (int i = 0; i < 300; i++) q.push_back(12'(i));
        drive(q);
        @(negedge clk);
        check("drop_saturate", {24'b0, drop_count}, 32'hFF);
        hold = 1'b0;
        wait_idle("ovf_drain_done");

        // SEQ wrap across 257 packets
        for (int p = 0; p < 257; p++) begin
            q.delete();
            for (int j = 0; j < 4; j++) q.push_back(12'($urandom));
            push_pkt(seq, q);
            seq = seq + 8'h01;
            drive(q);
            wait_idle("wrap_pkt_done");
        end

        // Reset during the fifth byte
        q = {12'h321, 12'h654, 12'h987, 12'hCBA};
        push_pkt(seq, q);
        base = n_starts;
        drive(q);
        k = 0;
        while (n_starts < base + 5 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("reach_fifth_byte", {31'b0, (k < 2000)}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_start",  {31'b0, uart_start}, 32'd0);
        check("mid_rst_data",   {24'b0, uart_data},  32'd0);
        check("mid_rst_active", {31'b0, pkt_active}, 32'd0);
        check("mid_rst_ovf",    {31'b0, overflow},   32'd0);
        check("mid_rst_drops",  {24'b0, drop_count}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_idle", {31'b0, pkt_active}, 32'd0);
        q = {12'h0AA, 12'h155, 12'h2FF, 12'h800};
        push_pkt(8'h00, q);
        drive(q);
        wait_idle("post_rst_pkt_done");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
